// File: rtl/vga_timing_controller.sv
// VGA timing generator: pixel divider, h/v counters with phase FSMs, and registered sync/blank/RGB outputs.
// Build macro VGA_TEST_PATTERN_EN replaces color_in with eight vertical colour bars.
module vga_timing_controller #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [23:0] color_in,
    output logic [9:0]  horizontal,
    output logic [9:0]  vertical,
    output logic        pixel_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic        vga_clk,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] VCLK_HIGH = DIV_W'((CLK_DIV + 1) / 2);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_AT = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_AT  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_BACK_AT  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_AT = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_AT  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_BACK_AT  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic       SYNC_ON    = (SYNC_POL != 0);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
            $fatal(1, "vga_timing_controller: H_TOTAL and V_TOTAL must be <= 1024, CLK_DIV >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick_reg, vclk_reg;
    logic [9:0]       h_reg, h_next, v_reg, v_next;
    phase_t           h_phase_reg, h_phase_next, v_phase_reg, v_phase_next;
    logic             h_wrap;
    logic             hsync_raw, vsync_raw, visible;
    logic             hsync_reg, vsync_reg, blank_n_reg, frame_start_reg;
    logic [23:0]      rgb_reg, pix_color;

    // Later boundaries win so a zero-width porch or pulse is skipped cleanly.
    function automatic phase_t next_phase(input logic [9:0] pos, input phase_t cur,
                                          input logic [9:0] front_at, input logic [9:0] sync_at,
                                          input logic [9:0] back_at);
        phase_t nxt;
        nxt = cur;
        if (pos == 10'd0)         nxt = PH_ACTIVE;
        else if (pos == back_at)  nxt = PH_BACK;
        else if (pos == sync_at)  nxt = PH_SYNC;
        else if (pos == front_at) nxt = PH_FRONT;
        return nxt;
    endfunction

    always_comb begin
        div_next     = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        h_wrap       = tick_reg && (h_reg == H_LAST);
        h_next       = h_reg;
        v_next       = v_reg;
        h_phase_next = h_phase_reg;
        v_phase_next = v_phase_reg;
        if (tick_reg) begin
            h_next       = h_wrap ? 10'd0 : h_reg + 10'd1;
            h_phase_next = next_phase(h_next, h_phase_reg, H_FRONT_AT, H_SYNC_AT, H_BACK_AT);
        end
        if (h_wrap) begin
            v_next       = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
            v_phase_next = next_phase(v_next, v_phase_reg, V_FRONT_AT, V_SYNC_AT, V_BACK_AT);
        end
    end

    assign hsync_raw = (h_phase_reg == PH_SYNC);
    assign vsync_raw = (v_phase_reg == PH_SYNC);
    assign visible   = (h_phase_reg == PH_ACTIVE) && (v_phase_reg == PH_ACTIVE);

`ifdef VGA_TEST_PATTERN_EN
    logic [12:0] bar_num;
    logic [12:0] bar_sel;
    logic [2:0]  bar;
    logic        unused_pattern;
    assign bar_num = {h_reg, 3'b000};
    assign bar_sel = bar_num / 13'(H_ACTIVE);
    assign bar     = bar_sel[2:0];
    // Bars 0..7: white, yellow, cyan, green, magenta, red, blue, black.
    assign pix_color      = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    assign unused_pattern = ^{color_in, bar_sel[12:3]};
`else
    assign pix_color = color_in;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            div_reg         <= '0;
            tick_reg        <= 1'b0;
            vclk_reg        <= 1'b0;
            h_reg           <= 10'd0;
            v_reg           <= 10'd0;
            h_phase_reg     <= PH_ACTIVE;
            v_phase_reg     <= PH_ACTIVE;
            hsync_reg       <= ~SYNC_ON;
            vsync_reg       <= ~SYNC_ON;
            blank_n_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
            rgb_reg         <= 24'd0;
        end else begin
            div_reg     <= div_next;
            tick_reg    <= (div_next == DIV_LAST);
            // High for the first half of each pixel, so it rises on the edge after the tick.
            vclk_reg    <= (div_next < VCLK_HIGH);
            h_reg       <= h_next;
            v_reg       <= v_next;
            h_phase_reg <= h_phase_next;
            v_phase_reg <= v_phase_next;
            if (tick_reg) begin
                hsync_reg       <= hsync_raw ? SYNC_ON : ~SYNC_ON;
                vsync_reg       <= vsync_raw ? SYNC_ON : ~SYNC_ON;
                blank_n_reg     <= visible;
                frame_start_reg <= (h_reg == 10'd0) && (v_reg == 10'd0);
                rgb_reg         <= visible ? pix_color : 24'd0;
            end
        end
    end

    assign horizontal  = h_reg;
    assign vertical    = v_reg;
    assign pixel_tick  = tick_reg;
    assign vga_clk     = vclk_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign blank_n     = blank_n_reg;
    assign sync_n      = 1'b0;
    assign frame_start = frame_start_reg;
    assign red         = rgb_reg[23:16];
    assign green       = rgb_reg[15:8];
    assign blue        = rgb_reg[7:0];
endmodule
